// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a streaming load port fills DEPTH words, and a
// byte-addressed fetch port returns registered instructions with one-cycle latency.
module instr_mem_loadable #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [CNT_W-1:0]  load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] DEPTH_I  = IDX_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              load_fire;
    logic              fetch_fire;
    logic [IDX_W-1:0]  fetch_index;
    logic [AW-1:0]     idx_lo;
    logic              misaligned;
    logic              in_range;
    logic              loaded;

    // Handshake readies are combinational so a same-cycle load_start can veto both ports.
    assign load_ready  = rst_n && (state == LOAD) && (load_count < DEPTH_C) && !load_start;
    assign fetch_ready = rst_n && (state != LOAD) && !load_start;
    assign load_fire   = load_valid && load_ready;
    assign fetch_fire  = fetch_req && fetch_ready;

    assign fetch_index = fetch_addr[ADDR_W-1:2];
    assign idx_lo      = fetch_index[AW-1:0];
    assign misaligned  = (fetch_addr[1:0] != 2'b00);
    assign in_range    = (fetch_index < DEPTH_I);
    assign loaded      = ({1'b0, idx_lo} < load_count);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state      <= LOAD;
                load_count <= '0;
            end else if (load_fire) begin
                load_count <= load_count + 1'b1;
                if (load_last || (load_count == LAST_IDX)) begin
                    state     <= RUN;
                    load_done <= 1'b1;
                end
            end
        end
    end

    // NOTE: the array has no reset; reads are gated by load_count, so stale
    // contents never reach instr and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[load_count[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            instr_valid <= fetch_fire;
            if (fetch_fire) begin
                if (misaligned || !in_range) begin
                    instr       <= '0;
                    fetch_fault <= 1'b1;
                end else begin
                    instr       <= loaded ? mem[idx_lo] : '0;
                    fetch_fault <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable (DEPTH=8): directed stimulus, a behavioural model
// checked every cycle, and literal expectations at the key points.
module tb_instr_mem_loadable;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic [CNT_W-1:0]  load_count;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;

    instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit running = 1'b1;
    bit watch_done = 1'b0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array, a count, and a "loading" flag.
    logic [31:0] m_mem [DEPTH];
    bit          m_loading = 1'b0;
    int          m_count = 0;
    bit          m_done = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    bit          m_fault = 1'b0;

    task automatic model_step();
        bit   accept;
        int   word;
        if (!rst_n) begin
            m_loading = 1'b0; m_count = 0; m_done = 1'b0;
            m_valid = 1'b0; m_instr = '0; m_fault = 1'b0;
            return;
        end
        accept  = fetch_req && !m_loading && !load_start;
        m_done  = 1'b0;
        m_valid = accept;
        if (accept) begin
            word = int'(fetch_addr / 4);
            if ((fetch_addr % 4) != 0 || fetch_addr >= 4 * DEPTH) begin
                m_instr = '0; m_fault = 1'b1;
            end else begin
                m_instr = (word < m_count) ? m_mem[word] : '0;
                m_fault = 1'b0;
            end
        end
        if (load_start) begin
            m_loading = 1'b1; m_count = 0;
        end else if (m_loading && load_valid && m_count < DEPTH) begin
            m_mem[m_count] = load_data;
            m_count++;
            if (load_last || m_count == DEPTH) begin
                m_loading = 1'b0; m_done = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial begin
        while (running) begin
            @(negedge clk);
            if (!running) break;
            check("load_ready",  32'(load_ready),  32'(rst_n && m_loading && m_count < DEPTH && !load_start));
            check("fetch_ready", 32'(fetch_ready), 32'(rst_n && !m_loading && !load_start));
            check("load_done",   32'(load_done),   32'(m_done));
            check("load_count",  32'(load_count),  32'(m_count));
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("instr",       instr,            m_instr);
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            if (watch_done && load_done) done_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                         input bit exp_fault, input string name);
        fetch_req = 1'b1; fetch_addr = addr;
        step();
        fetch_req = 1'b0;
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
        check({name, "_instr"}, instr, exp_instr);
        check({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
    endtask

    logic [31:0] prog [3] = '{32'h5129_4009, 32'h512A_4812, 32'h518D_581B};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_ready", 32'({load_ready, fetch_ready}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // IDLE fetch returns 0 without fault
        fetch(32'd0, 32'd0, 1'b0, "idle_fetch");
        check("idle_count", 32'(load_count), 32'd0);

        // Three-beat load terminated by load_last
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("ld3_done", 32'(load_done), 32'd1);
        check("ld3_count", 32'(load_count), 32'd3);
        step();
        check("ld3_done_once", 32'(load_done), 32'd0);

        // Back-to-back fetches, then unloaded / misaligned / out-of-range
        fetch(32'd0, 32'h5129_4009, 1'b0, "f0");
        fetch(32'd4, 32'h512A_4812, 1'b0, "f4");
        fetch(32'd8, 32'h518D_581B, 1'b0, "f8");
        step();
        check("hold_valid", 32'(instr_valid), 32'd0);
        check("hold_instr", instr, 32'h518D_581B);
        fetch(32'd12, 32'd0, 1'b0, "f12_unloaded");
        fetch(32'd6,  32'd0, 1'b1, "f6_misaligned");
        fetch(32'd32, 32'd0, 1'b1, "f32_range");

        // Nine beats without load_last: auto-complete after the eighth
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1; load_data = 32'hA000_0000 + 32'(i);
            step();
            if (i == 7) begin
                check("auto_done", 32'(load_done), 32'd1);
                check("auto_count", 32'(load_count), 32'd8);
                check("auto_ready", 32'(load_ready), 32'd0);
            end
        end
        load_valid = 1'b0;
        check("sat_count", 32'(load_count), 32'd8);
        fetch(32'd0,  32'hA000_0000, 1'b0, "mem0_kept");
        fetch(32'd28, 32'hA000_0007, 1'b0, "mem7");

        // load_start beats a same-cycle fetch and load beat
        load_start = 1'b1; fetch_req = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
        #1;
        check("start_fready", 32'(fetch_ready), 32'd0);
        check("start_lready", 32'(load_ready), 32'd0);
        step();
        load_start = 1'b0; fetch_req = 1'b0; load_valid = 1'b0;
        check("start_nofetch", 32'(instr_valid), 32'd0);
        check("start_count", 32'(load_count), 32'd0);

        // Reset mid-load after two of four beats
        watch_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'hC000_0000 + 32'(i);
            step();
        end
        load_data = 32'hC000_0002; fetch_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(load_count), 32'd0);
        check("mid_rst_outs", 32'({load_ready, fetch_ready, load_done, instr_valid, fetch_fault}), 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        load_valid = 1'b0; fetch_req = 1'b0;
        step();
        rst_n = 1'b1;
        fetch(32'd0, 32'd0, 1'b0, "post_rst_f0");
        repeat (3) step();
        check("no_load_done", 32'(done_seen), 32'd0);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
